fifo_read_streamer: RTL and testbench
=====================================

Name: fifo_read_streamer

Overview:
- Downstream consumer of the team's sync FIFO.
- Drives the FIFO read port, honouring the FIFO's one-cycle read latency, its one-cycle-lagged EMPTY flag, and its write-over-read priority.
- Re-presents the words as a valid/ready stream through a 2-entry skid buffer.
- Counts delivered words for debug.

Parameters:
p_DATA_WIDTH, 8, width of FIFO words and stream data
p_COUNT_WIDTH, 16, width of the delivered-word counter (wraps)

Ports:
i_CLK  input  1  clock; all state updates on rising edge
i_RESET  input  1  asynchronous, active-high reset
i_FIFO_EMPTY  input  1  FIFO empty flag (registered in FIFO, lags its occupancy by one cycle)
i_FIFO_WRITE  input  1  FIFO write request seen this cycle (a same-cycle read would be dropped by FIFO)
i_FIFO_DATA  input  p_DATA_WIDTH  FIFO registered read data, valid the cycle after a read request
o_FIFO_READ  output  1  read request to FIFO (combinational)
o_VALID  output  1  stream data valid
i_READY  input  1  downstream ready
o_DATA  output  p_DATA_WIDTH  stream data (skid head entry)
o_WORD_COUNT  output  p_COUNT_WIDTH  words delivered (o_VALID & i_READY), wraps modulo 2^p_COUNT_WIDTH

Behaviour:
- Reset is asynchronous, active-high; it applies while i_RESET is high.
  - Reset values: state IDLE, skid occupancy 0, o_VALID 0, o_DATA 0, o_WORD_COUNT 0.
  - o_FIFO_READ is forced 0 while i_RESET is high.
- Reset mid-read discards any in-flight word. The integrator resets the FIFO together with this block.
- State machine, two states:
  - IDLE: a read may issue. If o_FIFO_READ=1 at cycle t, the next state is WAIT.
  - WAIT: at the rising edge ending cycle t+1, the block captures i_FIFO_DATA into the skid tail and returns to IDLE.
- o_FIFO_READ = IDLE & !i_FIFO_EMPTY & !i_FIFO_WRITE & room.
  - room = (occupancy < 2) | (occupancy == 2 & i_READY).
- Flag settling: the earliest next read is cycle t+2. One read every two cycles is the maximum rate. This guarantees the EMPTY flag reflects the previous read before it is trusted.
- Write priority: no read issues in any cycle where i_FIFO_WRITE=1, so the FIFO never silently drops a read.
- Latency: FIFO read at t -> o_VALID=1 with that word at t+2 when the skid was empty.
- Skid buffer:
  - 2 entries, FIFO-ordered; o_DATA is the head.
  - o_VALID = (occupancy != 0).
  - Pop when o_VALID & i_READY.
  - Capture and pop in the same cycle keep occupancy unchanged; order is preserved.
  - Occupancy never exceeds 2. Capture into a full buffer is unreachable by construction; the bench asserts this.
- o_DATA holds stable while o_VALID=1 & i_READY=0.
- o_WORD_COUNT increments by 1 per pop and wraps from all-ones to 0.
- A FIFO empty at reset issues no reads. EMPTY deasserting one cycle late only delays the first read; no word is lost.

Test Plan:
- Single word: FIFO holds 0xA5, i_READY=1 -> o_FIFO_READ pulses once at t; o_VALID=1, o_DATA=0xA5 at t+2; o_WORD_COUNT=1; no further reads while EMPTY=1.
- Burst: FIFO preloaded 0x01,0x02,0x03, i_READY=1 -> reads at t, t+2, t+4; data 0x01,0x02,0x03 in order; o_WORD_COUNT=3; never two reads in consecutive cycles.
- Backpressure: i_READY=0 with 3 words queued -> exactly 2 reads; o_DATA holds 0x01; occupancy 2. Raise i_READY -> 0x01,0x02,0x03 delivered in order; no overflow.
- Write collision: i_FIFO_WRITE=1 in every cycle where a read would otherwise issue -> o_FIFO_READ stays 0. Drop i_FIFO_WRITE -> read issues the same cycle.
- Async reset mid-read: assert i_RESET during WAIT -> o_VALID=0, o_WORD_COUNT=0, o_FIFO_READ=0 immediately without a clock edge. After release with FIFO refilled with 0x5A -> normal delivery of 0x5A.
- Counter wrap: p_COUNT_WIDTH=4, deliver 17 words -> o_WORD_COUNT=1.

Source files
------------

// File: rtl/fifo_read_streamer.sv
// Reads words out of a one-cycle-latency sync FIFO and re-presents them as a
// valid/ready stream through a 2-entry skid buffer, counting delivered words.
module fifo_read_streamer #(
  parameter int p_DATA_WIDTH  = 8,
  parameter int p_COUNT_WIDTH = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RESET,
  input  logic                     i_FIFO_EMPTY,
  input  logic                     i_FIFO_WRITE,
  input  logic [p_DATA_WIDTH-1:0]  i_FIFO_DATA,
  output logic                     o_FIFO_READ,
  output logic                     o_VALID,
  input  logic                     i_READY,
  output logic [p_DATA_WIDTH-1:0]  o_DATA,
  output logic [p_COUNT_WIDTH-1:0] o_WORD_COUNT
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               occ_q, occ_d;
  logic [p_DATA_WIDTH-1:0]  head_q, head_d;
  logic [p_DATA_WIDTH-1:0]  tail_q, tail_d;
  logic [p_COUNT_WIDTH-1:0] count_q, count_d;

  logic room;
  logic rd;
  logic capture;
  logic pop;

  // A full skid still has room when its head leaves this cycle, because the
  // new word only lands one cycle later.
  assign room    = (occ_q < 2'd2) || ((occ_q == 2'd2) && i_READY);
  assign rd      = !i_RESET && (state_q == ST_IDLE) && !i_FIFO_EMPTY
                   && !i_FIFO_WRITE && room;
  assign capture = (state_q == ST_WAIT);
  assign pop     = (occ_q != 2'd0) && i_READY;

  assign o_FIFO_READ  = rd;
  assign o_VALID      = (occ_q != 2'd0);
  assign o_DATA       = head_q;
  assign o_WORD_COUNT = count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rd) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({capture, pop})
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0)      head_d = i_FIFO_DATA;
        else if (occ_q == 2'd1) tail_d = i_FIFO_DATA;
        if (occ_q != 2'd2)      occ_d  = occ_q + 2'd1;
      end
      2'b11: begin
        // Head leaves while the new word arrives; occupancy is unchanged.
        if (occ_q == 2'd1) begin
          head_d = i_FIFO_DATA;
        end else begin
          head_d = tail_q;
          tail_d = i_FIFO_DATA;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (pop) count_d = count_q + 1'b1;
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= ST_IDLE;
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: a lagged-EMPTY sync FIFO model feeds the DUT and
// a queue of written words is the expected delivery order.
module tb_fifo_read_streamer;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty;
  logic          fifo_write = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_read;
  logic          valid;
  logic          ready = 1'b1;
  logic [DW-1:0] data;
  logic [CW-1:0] word_count;
  logic [DW-1:0] wdata = '0;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  fifo_read_streamer #(.p_DATA_WIDTH(DW), .p_COUNT_WIDTH(CW)) dut (
    .i_CLK(clk), .i_RESET(rst), .i_FIFO_EMPTY(fifo_empty), .i_FIFO_WRITE(fifo_write),
    .i_FIFO_DATA(fifo_data), .o_FIFO_READ(fifo_read), .o_VALID(valid), .i_READY(ready),
    .o_DATA(data), .o_WORD_COUNT(word_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FIFO model: read data one cycle after the request, EMPTY registered from
  // the pre-edge occupancy so it lags by a cycle, write wins over read.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic          s_read = 1'b0, s_write = 1'b0;
  logic [DW-1:0] s_wdata = '0;

  always @(negedge clk) begin
    s_read  = fifo_read;
    s_write = fifo_write;
    s_wdata = wdata;
  end

  always @(posedge clk or posedge rst) begin
    cyc_n++;
    if (rst) begin
      fq.delete();
      exp_q.delete();
      fifo_empty <= 1'b1;
      fifo_data  <= '0;
    end else begin
      fifo_empty <= (fq.size() == 0);
      if (s_write) begin
        if (fq.size() < 32) begin
          fq.push_back(s_wdata);
          exp_q.push_back(s_wdata);
        end
      end else if (s_read) begin
        check("fifo_underflow", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) fifo_data <= fq.pop_front();
      end
    end
  end

  // Stream monitor and protocol rules.
  int            reads_total = 0;
  int            pops_total = 0;
  int            model_cnt = 0;
  int            rd_cyc[$];
  logic          prev_rd = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] m_exp;

  always @(negedge clk) begin
    if (rst) begin
      reads_total = 0;
      pops_total  = 0;
      model_cnt   = 0;
      prev_rd     = 1'b0;
      prev_hold   = 1'b0;
    end else begin
      if (fifo_read) begin
        check("rd_while_empty", 32'(fifo_empty), 32'd0);
        check("rd_while_write", 32'(fifo_write), 32'd0);
        check("rd_back_to_back", 32'(prev_rd), 32'd0);
        reads_total++;
        rd_cyc.push_back(cyc_n);
      end
      if (prev_hold) begin
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_data", 32'(data), 32'(prev_data));
      end
      check("word_count", 32'(word_count), 32'(model_cnt));
      if (valid && ready) begin
        check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          m_exp = exp_q.pop_front();
          check("pop_data", 32'(data), 32'(m_exp));
        end
        pops_total++;
        model_cnt = (model_cnt + 1) % (1 << CW);
      end
      check("no_overflow", 32'((reads_total - pops_total) <= 2), 32'd1);
      prev_rd   = fifo_read;
      prev_hold = valid && !ready;
      prev_data = data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] w);
    wdata      = w;
    fifo_write = 1'b1;
    cyc();
    fifo_write = 1'b0;
  endtask

  task automatic wait_read(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fifo_read) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic drain(input string tag);
    logic done;
    done  = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (exp_q.size() == 0 && !valid) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 32'(done), 32'd1);
    repeat (3) cyc();
  endtask

  int base_r;
  int base_c;

  initial begin
    // Reset state
    repeat (2) cyc();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_read", 32'(fifo_read), 32'd0);
    rst = 1'b0;
    repeat (3) cyc();

    // Single word, latency 2
    put(8'hA5);
    wait_read("t1_read_seen");
    @(negedge clk);
    @(negedge clk);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_data", 32'(data), 32'hA5);
    repeat (6) @(negedge clk);
    check("t1_count", 32'(word_count), 32'd1);
    check("t1_reads", 32'(reads_total), 32'd1);
    cyc();

    // Burst of three at one read per two cycles
    base_r = reads_total;
    base_c = rd_cyc.size();
    for (int i = 1; i <= 3; i++) begin
      wdata = 8'(i);
      fifo_write = 1'b1;
      cyc();
    end
    fifo_write = 1'b0;
    drain("t2_drain");
    check("t2_reads", 32'(reads_total - base_r), 32'd3);
    if (rd_cyc.size() >= base_c + 3) begin
      check("t2_gap0", 32'(rd_cyc[base_c+1] - rd_cyc[base_c]), 32'd2);
      check("t2_gap1", 32'(rd_cyc[base_c+2] - rd_cyc[base_c+1]), 32'd2);
    end
    check("t2_count", 32'(word_count), 32'd4);

    // Backpressure: skid fills to two, head held
    ready  = 1'b0;
    base_r = reads_total;
    for (int i = 1; i <= 3; i++) begin
      wdata = 8'(i);
      fifo_write = 1'b1;
      cyc();
    end
    fifo_write = 1'b0;
    repeat (20) cyc();
    check("t3_reads", 32'(reads_total - base_r), 32'd2);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_head", 32'(data), 32'h01);
    drain("t3_drain");
    check("t3_count", 32'(word_count), 32'd7);

    // Write collision holds reads off; read issues as soon as write drops
    base_r = reads_total;
    for (int i = 0; i < 8; i++) begin
      wdata = 8'(8'h10 + i);
      fifo_write = 1'b1;
      cyc();
    end
    check("t4_no_read", 32'(reads_total - base_r), 32'd0);
    fifo_write = 1'b0;
    #1;
    check("t4_read_now", 32'(fifo_read), 32'd1);
    drain("t4_drain");
    check("t4_count", 32'(word_count), 32'd15);

    // Async reset while a read is in flight
    ready = 1'b0;
    wdata = 8'h66;
    fifo_write = 1'b1;
    cyc();
    put(8'h77);
    wait_read("t5_read0");
    wait_read("t5_read1");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_data", 32'(data), 32'd0);
    check("t5_count", 32'(word_count), 32'd0);
    check("t5_read", 32'(fifo_read), 32'd0);
    cyc();
    cyc();
    rst   = 1'b0;
    ready = 1'b1;
    cyc();
    put(8'h5A);
    drain("t5_drain");
    check("t5_count_after", 32'(word_count), 32'd1);

    // Random traffic, 17 words, counter wraps to 1
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 17; i++) begin
      wdata = 8'($urandom);
      fifo_write = 1'b1;
      ready = 1'($urandom % 2);
      cyc();
      fifo_write = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        ready = 1'($urandom % 2);
        cyc();
      end
    end
    drain("t6_drain");
    check("t6_wrap_count", 32'(word_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
